// File: rtl/gpu_pkg.sv
// Shared GPU pixel-path constants, FSM encodings and a width helper.
package gpu_pkg;

    localparam int SPRITE_COUNT  = 256;
    localparam int SPRITE_ADDR_W = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Minimum bits to index v items; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_priority_select_if.sv
// Request/result handshake bundle for the sprite priority selector.
interface sprite_priority_select_if
    import gpu_pkg::*;
#(
    parameter int NUM_SPRITES = SPRITE_COUNT,
    parameter int ADDR_W      = SPRITE_ADDR_W,
    parameter int INDEX_W     = clog2(NUM_SPRITES)
);
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_SPRITES-1:0]        in_range;
    logic [NUM_SPRITES*ADDR_W-1:0] addr_in;
    logic                          out_valid;
    logic                          out_ready;
    logic [ADDR_W-1:0]             out_addr;
    logic [INDEX_W-1:0]            out_index;
    logic                          out_hit;

    modport master (
        output in_valid, in_range, addr_in, out_ready,
        input  in_ready, out_valid, out_addr, out_index, out_hit
    );

    modport slave (
        input  in_valid, in_range, addr_in, out_ready,
        output in_ready, out_valid, out_addr, out_index, out_hit
    );
endinterface

// File: rtl/sprite_priority_select_group_priority_encoder.sv
// Combinational GROUP-wide encoder: any-set flag and index of the highest set bit.
module group_priority_encoder
    import gpu_pkg::*;
#(
    parameter int GROUP = 16,
    parameter int IDX_W = (clog2(GROUP) > 0) ? clog2(GROUP) : 1
) (
    input  logic [GROUP-1:0] i_bits,
    output logic             o_any,
    output logic [IDX_W-1:0] o_idx
);
    always_comb begin
        o_any = |i_bits;
        o_idx = '0;
        // Ascending scan so the last hit, i.e. the highest bit, wins.
        for (int i = 0; i < GROUP; i++) begin
            if (i_bits[i]) o_idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/sprite_priority_select.sv
// Multi-cycle highest-index sprite selector: scans the captured mask GROUP bits
// per cycle from the top group down and stops at the first group with a hit.
module sprite_priority_select
    import gpu_pkg::*;
#(
    parameter int NUM_SPRITES = SPRITE_COUNT,
    parameter int ADDR_W      = SPRITE_ADDR_W,
    parameter int GROUP       = 16,
    parameter int INDEX_W     = clog2(NUM_SPRITES)
) (
    input logic                     clk,
    input logic                     rst,
    sprite_priority_select_if.slave bus
);
    localparam int NUM_GROUPS = NUM_SPRITES / GROUP;
    localparam int G_W        = (clog2(NUM_GROUPS) > 0) ? clog2(NUM_GROUPS) : 1;
    localparam int BIT_W      = (clog2(GROUP) > 0) ? clog2(GROUP) : 1;

    state_e                        r_state, w_state_nxt;
    logic [G_W-1:0]                r_g;
    logic [NUM_SPRITES-1:0]        r_mask;
    logic [NUM_SPRITES*ADDR_W-1:0] r_addr;
    logic                          r_out_valid;
    logic                          r_out_hit;
    logic [ADDR_W-1:0]             r_out_addr;
    logic [INDEX_W-1:0]            r_out_index;

    int                 w_base;
    logic [GROUP-1:0]   w_slice;
    logic               w_any;
    logic [BIT_W-1:0]   w_bit;
    logic [INDEX_W-1:0] w_idx;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic               w_accept;
    logic               w_last_grp;

    assign w_base     = int'(r_g) * GROUP;
    assign w_slice    = r_mask[w_base +: GROUP];
    assign w_idx      = INDEX_W'(w_base + int'(w_bit));
    // Only the winning slice is read, so junk in other address slices stays out.
    assign w_sel_addr = r_addr[int'(w_idx) * ADDR_W +: ADDR_W];
    assign w_last_grp = (r_g == '0);

    group_priority_encoder #(.GROUP(GROUP), .IDX_W(BIT_W)) u_enc (
        .i_bits (w_slice),
        .o_any  (w_any),
        .o_idx  (w_bit)
    );

    assign bus.in_ready  = (r_state == IDLE) && !rst;
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_hit   = r_out_hit;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_index = r_out_index;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SCAN;
            SCAN:    if (w_any || w_last_grp) w_state_nxt = DONE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_g         <= '0;
            r_mask      <= '0;
            r_addr      <= '0;
            r_out_valid <= 1'b0;
            r_out_hit   <= 1'b0;
            r_out_addr  <= '0;
            r_out_index <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mask <= bus.in_range;
                        r_addr <= bus.addr_in;
                        r_g    <= G_W'(NUM_GROUPS - 1);
                    end
                end
                SCAN: begin
                    if (w_any) begin
                        r_out_index <= w_idx;
                        r_out_addr  <= w_sel_addr;
                        r_out_hit   <= 1'b1;
                        r_out_valid <= 1'b1;
                    end else if (w_last_grp) begin
                        r_out_index <= '0;
                        r_out_addr  <= '0;
                        r_out_hit   <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_g <= r_g - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_priority_select.sv
// Directed bench for sprite_priority_select: default GROUP=16 build plus a GROUP=256 build.
module tb_sprite_priority_select;
    localparam int NS = 256;
    localparam int AW = 23;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [NS*AW-1:0] av;

    always #5 clk = ~clk;

    sprite_priority_select_if #(.NUM_SPRITES(NS), .ADDR_W(AW), .INDEX_W(8)) bus ();
    sprite_priority_select_if #(.NUM_SPRITES(NS), .ADDR_W(AW), .INDEX_W(8)) bus2 ();

    sprite_priority_select #(.NUM_SPRITES(NS), .ADDR_W(AW), .GROUP(16), .INDEX_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sprite_priority_select #(.NUM_SPRITES(NS), .ADDR_W(AW), .GROUP(256), .INDEX_W(8)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Stimulus only: issue one request on bus and return cycles from accept to out_valid (-1 on timeout).
    task automatic issue(input logic [NS-1:0] m, output int lat);
        int w;
        w = 0;
        bus.in_range = m;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            lat = -1;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%0b exp=0", bus.in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.out_hit !== 1'b0) begin failures++; $display("FAIL reset_out_hit got=%0b exp=0", bus.out_hit); end
        checks++; if (bus.out_addr !== 23'h0) begin failures++; $display("FAIL reset_out_addr got=%0h exp=0", bus.out_addr); end
        checks++; if (bus.out_index !== 8'd0) begin failures++; $display("FAIL reset_out_index got=%0d exp=0", bus.out_index); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    endtask

    task automatic test_single_200();
        logic [NS-1:0] m;
        int lat;
        m = '0; m[200] = 1'b1;
        issue(m, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL s200_latency got=%0d exp=4", lat); end
        checks++; if (bus.out_hit !== 1'b1) begin failures++; $display("FAIL s200_hit got=%0b exp=1", bus.out_hit); end
        checks++; if (bus.out_index !== 8'd200) begin failures++; $display("FAIL s200_index got=%0d exp=200", bus.out_index); end
        checks++; if (bus.out_addr !== 23'h12345) begin failures++; $display("FAIL s200_addr got=%0h exp=12345", bus.out_addr); end
        bus.out_ready = 1'b1; #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL s200_ready_in_done got=%0b exp=0", bus.in_ready); end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL s200_valid_cleared got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL s200_back_idle got=%0b exp=1", bus.in_ready); end
        checks++; if (bus.out_index !== 8'd200) begin failures++; $display("FAIL s200_index_kept got=%0d exp=200", bus.out_index); end
    endtask

    task automatic test_top_group();
        logic [NS-1:0] m;
        int lat;
        m = '0; m[3] = 1'b1; m[255] = 1'b1;
        issue(m, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL top_latency got=%0d exp=1", lat); end
        checks++; if (bus.out_index !== 8'd255) begin failures++; $display("FAIL top_index got=%0d exp=255", bus.out_index); end
        checks++; if (bus.out_addr !== 23'h7FFFFF) begin failures++; $display("FAIL top_addr got=%0h exp=7fffff", bus.out_addr); end
        consume();
    endtask

    task automatic test_empty_and_bottom();
        logic [NS-1:0] m;
        int lat;
        m = '0;
        issue(m, lat);
        checks++; if (lat !== 16) begin failures++; $display("FAIL empty_latency got=%0d exp=16", lat); end
        checks++; if (bus.out_hit !== 1'b0) begin failures++; $display("FAIL empty_hit got=%0b exp=0", bus.out_hit); end
        checks++; if (bus.out_addr !== 23'h0) begin failures++; $display("FAIL empty_addr got=%0h exp=0", bus.out_addr); end
        checks++; if (bus.out_index !== 8'd0) begin failures++; $display("FAIL empty_index got=%0d exp=0", bus.out_index); end
        consume();
        m = '0; m[0] = 1'b1;
        issue(m, lat);
        checks++; if (lat !== 16) begin failures++; $display("FAIL s0_latency got=%0d exp=16", lat); end
        checks++; if (bus.out_hit !== 1'b1) begin failures++; $display("FAIL s0_hit got=%0b exp=1", bus.out_hit); end
        checks++; if (bus.out_index !== 8'd0) begin failures++; $display("FAIL s0_index got=%0d exp=0", bus.out_index); end
        checks++; if (bus.out_addr !== 23'h0ABCD) begin failures++; $display("FAIL s0_addr got=%0h exp=0abcd", bus.out_addr); end
        consume();
    endtask

    task automatic test_backpressure();
        logic [NS-1:0] m;
        int lat;
        m = '0; m[100] = 1'b1; m[37] = 1'b1;
        issue(m, lat);
        checks++; if (lat !== 10) begin failures++; $display("FAIL bp_latency got=%0d exp=10", lat); end
        m = '0; m[255] = 1'b1;
        bus.in_range = m;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_index !== 8'd100 || bus.out_addr !== 23'h55AA5 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d valid=%0b index=%0d addr=%0h in_ready=%0b exp 1/100/55aa5/0", i, bus.out_valid, bus.out_index, bus.out_addr, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1; #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_on_handshake got=%0b exp=0", bus.in_ready); end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_idle valid=%0b in_ready=%0b exp 0/1", bus.out_valid, bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_accepted in_ready=%0b exp=0", bus.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_index !== 8'd255) begin failures++; $display("FAIL bp_second valid=%0b index=%0d exp 1/255", bus.out_valid, bus.out_index); end
        consume();
    endtask

    task automatic test_reset_midscan();
        int rose;
        bus.in_range = '0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_hit !== 1'b0 || bus.out_addr !== 23'h0 || bus.out_index !== 8'd0) begin
            failures++;
            $display("FAIL midrst_outputs valid=%0b hit=%0b addr=%0h index=%0d exp all 0", bus.out_valid, bus.out_hit, bus.out_addr, bus.out_index);
        end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%0b exp=1", bus.in_ready); end
        rose = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) rose++;
        end
        checks++; if (rose !== 0) begin failures++; $display("FAIL midrst_no_output got=%0d exp=0", rose); end
    endtask

    task automatic test_group256();
        logic [NS-1:0]   m;
        logic [NS*AW-1:0] a2;
        int t[$];
        a2 = '0;
        a2[17*AW +: AW]  = 23'h11111;
        a2[130*AW +: AW] = 23'h2468A;
        m = '0; m[17] = 1'b1; m[130] = 1'b1;
        bus2.addr_in  = a2;
        bus2.in_range = m;
        bus2.in_valid = 1'b1;
        #1;
        checks++; if (bus2.in_ready !== 1'b1) begin failures++; $display("FAIL g256_in_ready got=%0b exp=1", bus2.in_ready); end
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus2.out_valid !== 1'b1) begin failures++; $display("FAIL g256_latency valid=%0b exp=1", bus2.out_valid); end
        checks++; if (bus2.out_index !== 8'd130) begin failures++; $display("FAIL g256_index got=%0d exp=130", bus2.out_index); end
        checks++; if (bus2.out_addr !== 23'h2468A) begin failures++; $display("FAIL g256_addr got=%0h exp=2468a", bus2.out_addr); end
        bus2.out_ready = 1'b1;
        @(posedge clk); #1;
        bus2.in_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (bus2.out_valid) begin
                t.push_back(c);
                checks++; if (bus2.out_index !== 8'd130) begin failures++; $display("FAIL g256_b2b_index cyc=%0d got=%0d exp=130", c, bus2.out_index); end
            end
        end
        bus2.in_valid = 1'b0;
        checks++; if (t.size() !== 3) begin failures++; $display("FAIL g256_b2b_count got=%0d exp=3", t.size()); end
        if (t.size() >= 3) begin
            checks++; if (t[1] - t[0] !== 3 || t[2] - t[1] !== 3) begin failures++; $display("FAIL g256_b2b_period got=%0d,%0d exp=3,3", t[1] - t[0], t[2] - t[1]); end
        end
        repeat (3) @(posedge clk);
        #1;
        bus2.out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_range = '0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.in_range = '0; bus2.addr_in = '0;
        av = 'x;
        av[200*AW +: AW] = 23'h12345;
        av[255*AW +: AW] = 23'h7FFFFF;
        av[3*AW +: AW]   = 23'h33333;
        av[0*AW +: AW]   = 23'h0ABCD;
        av[100*AW +: AW] = 23'h55AA5;
        av[37*AW +: AW]  = 23'h00037;
        bus.addr_in = av;
        test_reset();
        test_single_200();
        test_top_group();
        test_empty_and_bottom();
        test_backpressure();
        test_reset_midscan();
        test_group256();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
